// File: rtl/llr_frame_loader.sv
// llr_frame_loader: double-buffered serial-to-parallel LLR frame packer feeding a parallel decoder core.
// Optional LLR_SAT_COUNT_EN adds a per-bank count of saturated samples on out_sat_cnt.
module llr_frame_loader #(
   parameter int W         = 6,
   parameter int FRAME_LEN = 64,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [W-1:0]           in_llr,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ack,
   output logic [FRAME_LEN*W-1:0] out_llr,
   output logic [CNT_W-1:0]       out_sat_cnt,
   output logic                   len_err
);
   localparam int PTR_W = $clog2(FRAME_LEN);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);

   typedef enum logic {S_FILL, S_WAIT} state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic                   wr_bank_q, wr_bank_d;
   logic                   rd_bank_q, rd_bank_d;
   logic                   len_err_q, len_err_d;
   logic [1:0]             full_q, full_d;
   logic [FRAME_LEN*W-1:0] data_q [2];
   logic [FRAME_LEN*W-1:0] data_d [2];
   logic                   accept, at_last, ack, other_rel;

   assign in_ready  = (state_q == S_FILL) && !rst;
   assign accept    = in_valid && in_ready;
   assign at_last   = wr_ptr_q == LAST_PTR;
   assign ack       = out_ack && full_q[rd_bank_q];
   assign other_rel = ack && (rd_bank_q != wr_bank_q);
   assign out_valid = full_q[rd_bank_q];
   assign out_llr   = data_q[rd_bank_q];
   assign len_err   = len_err_q;

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q ^ ack;
      full_d    = full_q;
      data_d    = data_q;
      len_err_d = accept && (in_last != at_last);
      if (ack)
         full_d[rd_bank_q] = 1'b0;
      if (accept) begin
         data_d[wr_bank_q][wr_ptr_q*W +: W] = in_llr;
         wr_ptr_d = at_last ? '0 : wr_ptr_q + 1'b1;
      end
      // A completed bank may hand over immediately if its partner is empty or being released now
      if (accept && at_last) begin
         full_d[wr_bank_q] = 1'b1;
         if (!full_q[~wr_bank_q] || other_rel)
            wr_bank_d = ~wr_bank_q;
         else
            state_d = S_WAIT;
      end
      if (state_q == S_WAIT && other_rel) begin
         wr_bank_d = ~wr_bank_q;
         state_d   = S_FILL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FILL;
         wr_ptr_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         len_err_q <= 1'b0;
         data_q[0] <= '0;
         data_q[1] <= '0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         len_err_q <= len_err_d;
         data_q[0] <= data_d[0];
         data_q[1] <= data_d[1];
      end
   end

`ifdef LLR_SAT_COUNT_EN
   logic [CNT_W-1:0] sat_q [2];
   logic [CNT_W-1:0] sat_d [2];
   logic             is_sat;

   assign is_sat      = (in_llr == {1'b0, {(W-1){1'b1}}}) || (in_llr == {1'b1, {(W-1){1'b0}}});
   assign out_sat_cnt = sat_q[rd_bank_q];

   // The first sample of a frame restarts its bank's count
   always_comb begin
      sat_d = sat_q;
      if (accept)
         sat_d[wr_bank_q] = ((wr_ptr_q == '0) ? '0 : sat_q[wr_bank_q]) + CNT_W'(is_sat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sat_q[0] <= '0;
         sat_q[1] <= '0;
      end else begin
         sat_q[0] <= sat_d[0];
         sat_q[1] <= sat_d[1];
      end
   end
`else
   assign out_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_llr_frame_loader.sv
// tb_llr_frame_loader: table-driven per-cycle checks of llr_frame_loader with W=6, FRAME_LEN=4.
module tb_llr_frame_loader;
   localparam int W = 6;
   localparam int N = 4;
   localparam int CW = $clog2(N + 1);
`ifdef LLR_SAT_COUNT_EN
   localparam int SAT_H = 2;
`else
   localparam int SAT_H = 0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_llr = '0;
   logic            in_last = 1'b0;
   logic            out_valid;
   logic            out_ack = 1'b0;
   logic [N*W-1:0]  out_llr;
   logic [CW-1:0]   out_sat_cnt;
   logic            len_err;

   int errors = 0;
   int checks = 0;

   llr_frame_loader #(.W(W), .FRAME_LEN(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_llr(in_llr),
      .in_last(in_last), .out_valid(out_valid), .out_ack(out_ack), .out_llr(out_llr),
      .out_sat_cnt(out_sat_cnt), .len_err(len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v; int d; logic l; logic a;
      logic er; logic ev; logic ee; logic c; logic [N*W-1:0] el; int es;
   } row_t;

   row_t tv[$];

   function automatic row_t rec(logic v, int d, logic l, logic a, logic er, logic ev, logic ee,
                                logic c, logic [N*W-1:0] el, int es);
      row_t r;
      r.v = v; r.d = d; r.l = l; r.a = a; r.er = er; r.ev = ev; r.ee = ee; r.c = c; r.el = el; r.es = es;
      return r;
   endfunction

   function automatic logic [N*W-1:0] pack(int a, int b, int c, int d);
      return {d[W-1:0], c[W-1:0], b[W-1:0], a[W-1:0]};
   endfunction

   task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
      end
   endtask

   task automatic step(int id, row_t r);
      in_valid = r.v;
      in_llr   = r.d[W-1:0];
      in_last  = r.l;
      out_ack  = r.a;
      @(posedge clk);
      #1;
      chk("in_ready", id, 32'(in_ready), 32'(r.er));
      chk("out_valid", id, 32'(out_valid), 32'(r.ev));
      chk("len_err", id, 32'(len_err), 32'(r.ee));
      if (r.c) begin
         chk("out_llr", id, 32'(out_llr), 32'(r.el));
         chk("out_sat_cnt", id, 32'(out_sat_cnt), r.es[31:0]);
      end
   endtask

   initial begin
      logic [N*W-1:0] fa, fb, fc, fd, fe, ff, fg, fh, fi;
      fa = pack(1, -2, 3, -4);
      fb = pack(5, 6, 7, 8);
      fc = pack(10, 11, 12, 13);
      fd = pack(-10, -11, -12, -13);
      fe = pack(20, -20, 21, -21);
      ff = pack(1, 2, 3, 4);
      fg = pack(-1, -2, -3, -4);
      fh = pack(31, -32, 30, -31);
      fi = pack(2, 4, 6, 8);
      // frame A, then B with no ack: WAIT, stray valid ignored, ack releases
      tv.push_back(rec(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -2, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 3, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -4, 1, 0, 1, 1, 0, 1, fa, 0));
      tv.push_back(rec(1, 5, 0, 0, 1, 1, 0, 1, fa, 0));
      tv.push_back(rec(1, 6, 0, 0, 1, 1, 0, 1, fa, 0));
      tv.push_back(rec(1, 7, 0, 0, 1, 1, 0, 1, fa, 0));
      tv.push_back(rec(1, 8, 1, 0, 0, 1, 0, 1, fa, 0));
      tv.push_back(rec(1, 9, 0, 0, 0, 1, 0, 1, fa, 0));
      tv.push_back(rec(0, 0, 0, 1, 1, 1, 0, 1, fb, 0));
      // C, D, E back to back with ack held high
      tv.push_back(rec(1, 10, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 11, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 12, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 13, 1, 1, 1, 1, 0, 1, fc, 0));
      tv.push_back(rec(1, -10, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -11, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -12, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -13, 1, 1, 1, 1, 0, 1, fd, 0));
      tv.push_back(rec(1, 20, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -20, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 21, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -21, 1, 1, 1, 1, 0, 1, fe, 0));
      // F completes in the same cycle E is acked: no stall
      tv.push_back(rec(1, 1, 0, 0, 1, 1, 0, 1, fe, 0));
      tv.push_back(rec(1, 2, 0, 0, 1, 1, 0, 1, fe, 0));
      tv.push_back(rec(1, 3, 0, 0, 1, 1, 0, 1, fe, 0));
      tv.push_back(rec(1, 4, 1, 1, 1, 1, 0, 1, ff, 0));
      // G: early in_last and missing in_last both flag len_err
      tv.push_back(rec(1, -1, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -2, 1, 0, 1, 0, 1, 0, 0, 0));
      tv.push_back(rec(1, -3, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -4, 0, 0, 1, 1, 1, 1, fg, 0));
      tv.push_back(rec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      // H: saturated values
      tv.push_back(rec(1, 31, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -32, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 30, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, -31, 1, 0, 1, 1, 0, 1, fh, SAT_H));
      tv.push_back(rec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 7, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(rec(1, 8, 0, 0, 1, 0, 0, 0, 0, 0));

      rst = 1'b1;
      step(900, rec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      step(901, rec(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 902, 32'(in_ready), 32'd1);

      for (int i = 0; i < tv.size(); i++)
         step(i, tv[i]);

      // reset mid-frame, then a fresh frame must be packed from entry 0
      rst = 1'b1;
      step(910, rec(1, 9, 0, 0, 0, 0, 0, 1, 0, 0));
      rst = 1'b0;
      #1;
      chk("ready_after_rst2", 911, 32'(in_ready), 32'd1);
      step(912, rec(1, 2, 0, 0, 1, 0, 0, 0, 0, 0));
      step(913, rec(1, 4, 0, 0, 1, 0, 0, 0, 0, 0));
      step(914, rec(1, 6, 0, 0, 1, 0, 0, 0, 0, 0));
      step(915, rec(1, 8, 1, 0, 1, 1, 0, 1, fi, 0));
      step(916, rec(0, 0, 0, 0, 1, 1, 0, 1, fi, 0));
      step(917, rec(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
